// File: rtl/kernel_run_pkg.sv
// Shared types and constants for the kernel run sequencer.
package kernel_run_pkg;

    localparam int unsigned NUM_LANES    = 8;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned NIB_PER_LANE = DATA_W / 4;
    localparam int unsigned DUMP_LEN     = NUM_LANES * NIB_PER_LANE;
    localparam int unsigned LANE_W       = $clog2(NUM_LANES);
    localparam int unsigned NIB_W        = $clog2(NIB_PER_LANE);
    localparam int unsigned RUN_W        = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DUMP,
        ST_GAP,
        ST_FINISH
    } run_state_e;

endpackage

// File: rtl/kernel_run_ctrl_if.sv
// Kernel ap_ctrl_hs handshake, output-stream taps and checksum dump port.
interface kernel_run_ctrl_if;
    import kernel_run_pkg::*;

    logic                          ap_done;
    logic                          ap_ready;
    logic                          ap_idle;
    logic [NUM_LANES-1:0]          lane_write;
    logic [NUM_LANES*DATA_W-1:0]   lane_din;
    logic                          ap_start;
    logic                          probe_out;
    logic [3:0]                    data_out;
    logic                          data_valid;
    logic [RUN_W-1:0]              run_cnt;
    logic                          all_done;

    // Sequencer side
    modport master (
        input  ap_done, ap_ready, ap_idle, lane_write, lane_din,
        output ap_start, probe_out, data_out, data_valid, run_cnt, all_done
    );

    // Kernel / board side
    modport slave (
        output ap_done, ap_ready, ap_idle, lane_write, lane_din,
        input  ap_start, probe_out, data_out, data_valid, run_cnt, all_done
    );

endinterface

// File: rtl/lane_xor_acc.sv
// Per-lane XOR checksum accumulator with a nibble shift register for the dump.
module lane_xor_acc
    import kernel_run_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    input  logic              take,
    output logic [3:0]        nib_c
);

    logic [DATA_W-1:0] chk_q;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sum_c;

    // Checksum including this cycle's write, so a write coincident with done is kept
    assign sum_c = (acc_en && wr) ? (chk_q ^ din) : chk_q;

    // Nibble presented when this lane is taken: fresh sum on load, else shift-register head
    assign nib_c = load ? sum_c[DATA_W-1 -: 4] : sr_q[DATA_W-1 -: 4];

    // Accumulator: clear on run start, fold writes while the run is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else if (clr) begin
            chk_q <= '0;
        end else if (acc_en && wr) begin
            chk_q <= sum_c;
        end
    end

    // Dump shift register: parallel load, pop one nibble per take
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= take ? {sum_c[DATA_W-5:0], 4'h0} : sum_c;
        end else if (take) begin
            sr_q <= {sr_q[DATA_W-5:0], 4'h0};
        end
    end

endmodule

// File: rtl/kernel_run_ctrl.sv
// Launches the kernel NUM_RUNS times and dumps per-lane XOR checksums as nibbles.
module kernel_run_ctrl
    import kernel_run_pkg::*;
#(
    parameter int unsigned NUM_RUNS   = 2,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    kernel_run_ctrl_if.master bus
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    run_state_e         state_q;
    run_state_e         state_d;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_d;
    logic [LANE_W-1:0]  lane_idx_q;
    logic [LANE_W-1:0]  lane_idx_d;
    logic [NIB_W-1:0]   nib_idx_q;
    logic [NIB_W-1:0]   nib_idx_d;
    logic [RUN_W-1:0]   run_cnt_q;
    logic [RUN_W-1:0]   run_cnt_d;

    logic               acc_clr;
    logic               acc_en;
    logic               load;
    logic               take_en;
    logic [LANE_W-1:0]  take_lane;
    logic [3:0]         data_out_d;

    logic               ap_start_q;
    logic               probe_q;
    logic [3:0]         data_out_q;
    logic               data_valid_q;
    logic               all_done_q;

    logic [3:0]         lane_nib [NUM_LANES];

    // Next-state, counters and lane control
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        lane_idx_d = lane_idx_q;
        nib_idx_d  = nib_idx_q;
        run_cnt_d  = run_cnt_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        load       = 1'b0;
        take_en    = 1'b0;
        take_lane  = lane_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ap_idle) begin
                    state_d = ST_START;
                    acc_clr = 1'b1;
                end
            end
            ST_START, ST_WAIT: begin
                acc_en = 1'b1;
                if (bus.ap_done) begin
                    // Done ends the run; ready+done together skips WAIT
                    state_d    = ST_DUMP;
                    load       = 1'b1;
                    take_en    = 1'b1;
                    take_lane  = '0;
                    lane_idx_d = '0;
                    nib_idx_d  = '0;
                    if (run_cnt_q < RUN_W'(NUM_RUNS)) begin
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                    end
                end else if ((state_q == ST_START) && bus.ap_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_DUMP: begin
                if ((lane_idx_q == LANE_W'(NUM_LANES - 1)) &&
                    (nib_idx_q == NIB_W'(NIB_PER_LANE - 1))) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    take_en = 1'b1;
                    if (nib_idx_q == NIB_W'(NIB_PER_LANE - 1)) begin
                        lane_idx_d = lane_idx_q + LANE_W'(1);
                        nib_idx_d  = '0;
                    end else begin
                        nib_idx_d = nib_idx_q + NIB_W'(1);
                    end
                    take_lane = lane_idx_d;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (run_cnt_q < RUN_W'(NUM_RUNS)) begin
                        state_d = ST_START;
                        acc_clr = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_FINISH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Nibble selected for the dump output register
    always_comb begin
        data_out_d = 4'h0;
        if (take_en) begin
            data_out_d = lane_nib[take_lane];
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            lane_idx_q   <= '0;
            nib_idx_q    <= '0;
            run_cnt_q    <= '0;
            ap_start_q   <= 1'b0;
            probe_q      <= 1'b0;
            data_out_q   <= 4'h0;
            data_valid_q <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            lane_idx_q   <= lane_idx_d;
            nib_idx_q    <= nib_idx_d;
            run_cnt_q    <= run_cnt_d;
            ap_start_q   <= (state_d == ST_START);
            probe_q      <= (state_d == ST_START) || (state_d == ST_WAIT);
            data_out_q   <= data_out_d;
            data_valid_q <= (state_d == ST_DUMP);
            all_done_q   <= (state_d == ST_FINISH);
        end
    end

    // One accumulator per output stream
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_xor_acc u_acc (
            .clk    (ap_clk),
            .rst    (ap_rst),
            .clr    (acc_clr),
            .acc_en (acc_en),
            .wr     (bus.lane_write[k]),
            .din    (bus.lane_din[k*DATA_W +: DATA_W]),
            .load   (load),
            .take   (take_en && (take_lane == LANE_W'(k))),
            .nib_c  (lane_nib[k])
        );
    end

    assign bus.ap_start   = ap_start_q;
    assign bus.probe_out  = probe_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.run_cnt    = run_cnt_q;
    assign bus.all_done   = all_done_q;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Directed bench for kernel_run_ctrl: run sequencing, checksum dumps, reset and handshake timing.
module tb_kernel_run_ctrl;
    import kernel_run_pkg::*;

    localparam int unsigned BUS_W = NUM_LANES * DATA_W;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [BUS_W-1:0] got;
    logic [BUS_W-1:0] exp_v;
    int               hi;

    kernel_run_ctrl_if bus ();

    kernel_run_ctrl #(
        .NUM_RUNS   (2),
        .GAP_CYCLES (16)
    ) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        bus.ap_done    = 1'b0;
        bus.ap_ready   = 1'b0;
        bus.lane_write = '0;
        bus.lane_din   = '0;
    endtask

    task automatic set_lane(input int k, input logic [DATA_W-1:0] v);
        bus.lane_write[k]              = 1'b1;
        bus.lane_din[k*DATA_W +: DATA_W] = v;
    endtask

    function automatic logic [DATA_W-1:0] lane_of(input logic [BUS_W-1:0] v, input int k);
        return v[BUS_W-1-k*DATA_W -: DATA_W];
    endfunction

    // Capture a full dump starting at the current (first) dump cycle; optional junk traffic
    task automatic capture(input logic stray, output logic [BUS_W-1:0] g);
        int nv;
        nv = 0;
        g  = '0;
        for (int i = 0; i < int'(DUMP_LEN); i++) begin
            if (bus.data_valid === 1'b1) nv++;
            g[BUS_W-1-4*i -: 4] = bus.data_out;
            if (stray) begin
                bus.lane_write = NUM_LANES'($urandom);
                for (int k = 0; k < int'(NUM_LANES); k++) bus.lane_din[k*DATA_W +: DATA_W] = $urandom;
                bus.ap_done = (i == 20);
            end
            tick();
        end
        clear_inputs();
        check("dump_valid_cycles", DATA_W'(nv), DATA_W'(DUMP_LEN));
        check("dump_end_valid", 32'(bus.data_valid), 32'd0);
    endtask

    task automatic check_dump(input string tag, input logic [BUS_W-1:0] g, input logic [BUS_W-1:0] e);
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            check($sformatf("%s_lane%0d", tag, k), lane_of(g, k), lane_of(e, k));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ap_idle = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("rst_ap_start", 32'(bus.ap_start), 32'd0);
        check("rst_probe", 32'(bus.probe_out), 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_run_cnt", 32'(bus.run_cnt), 32'd0);
        check("rst_all_done", 32'(bus.all_done), 32'd0);

        // Run 1: lane 3 writes 0xF0 (in START) then 0x0F (in WAIT)
        rst = 1'b0;
        tick();
        check("start_rise", 32'(bus.ap_start), 32'd1);
        check("start_probe", 32'(bus.probe_out), 32'd1);
        bus.ap_ready = 1'b1;
        set_lane(3, 32'h0000_00F0);
        tick();
        check("start_fall", 32'(bus.ap_start), 32'd0);
        check("wait_probe", 32'(bus.probe_out), 32'd1);
        clear_inputs();
        set_lane(3, 32'h0000_000F);
        tick();
        clear_inputs();
        repeat (98) tick();
        check("wait_no_valid", 32'(bus.data_valid), 32'd0);
        bus.ap_done = 1'b1;
        tick();
        bus.ap_done = 1'b0;
        check("run1_cnt", 32'(bus.run_cnt), 32'd1);
        check("run1_probe_low", 32'(bus.probe_out), 32'd0);
        capture(1'b1, got);
        exp_v = '0;
        exp_v[BUS_W-1-3*DATA_W -: DATA_W] = 32'h0000_00FF;
        check_dump("run1", got, exp_v);

        // Gap with stray writes and a stray done
        for (int i = 0; i < 15; i++) begin
            bus.lane_write = NUM_LANES'($urandom);
            bus.lane_din[0 +: DATA_W] = $urandom;
            bus.ap_done = (i == 5);
            tick();
        end
        clear_inputs();
        check("gap_start_low", 32'(bus.ap_start), 32'd0);
        check("gap_done_ignored", 32'(bus.run_cnt), 32'd1);
        tick();
        check("restart_timing", 32'(bus.ap_start), 32'd1);

        // Run 2: ready, done and a lane-0 write all in the same cycle
        bus.ap_ready = 1'b1;
        bus.ap_done  = 1'b1;
        set_lane(0, 32'hDEAD_BEEF);
        tick();
        clear_inputs();
        check("coinc_start_low", 32'(bus.ap_start), 32'd0);
        check("coinc_valid", 32'(bus.data_valid), 32'd1);
        check("run2_cnt", 32'(bus.run_cnt), 32'd2);
        capture(1'b0, got);
        exp_v = '0;
        exp_v[BUS_W-1 -: DATA_W] = 32'hDEAD_BEEF;
        check_dump("run2", got, exp_v);
        repeat (15) tick();
        check("pre_finish_all_done", 32'(bus.all_done), 32'd0);
        tick();
        check("finish_all_done", 32'(bus.all_done), 32'd1);
        check("finish_no_start", 32'(bus.ap_start), 32'd0);
        bus.ap_done = 1'b1;
        tick();
        bus.ap_done = 1'b0;
        tick();
        check("third_done_cnt", 32'(bus.run_cnt), 32'd2);
        check("third_done_all_done", 32'(bus.all_done), 32'd1);

        // Reset from FINISH, then slow idle / slow ready
        rst = 1'b1;
        bus.ap_idle = 1'b0;
        tick();
        check("rst2_all_done", 32'(bus.all_done), 32'd0);
        check("rst2_run_cnt", 32'(bus.run_cnt), 32'd0);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ap_start === 1'b1) hi++;
        end
        check("idle_hold", DATA_W'(hi), 32'd0);
        bus.ap_idle = 1'b1;
        tick();
        hi = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.ap_start === 1'b1) hi++;
            bus.ap_ready = (i == 6);
            tick();
        end
        bus.ap_ready = 1'b0;
        check("slow_ready_high_cycles", DATA_W'(hi), 32'd7);
        check("slow_ready_fall", 32'(bus.ap_start), 32'd0);
        set_lane(5, 32'hAAAA_5555);
        tick();
        clear_inputs();
        bus.ap_done = 1'b1;
        tick();
        bus.ap_done = 1'b0;
        repeat (9) tick();
        check("middump_valid", 32'(bus.data_valid), 32'd1);

        // Reset at dump cycle 10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("middump_rst_valid", 32'(bus.data_valid), 32'd0);
        check("middump_rst_data", 32'(bus.data_out), 32'd0);
        check("middump_rst_run_cnt", 32'(bus.run_cnt), 32'd0);
        check("middump_rst_probe", 32'(bus.probe_out), 32'd0);
        check("middump_rst_start", 32'(bus.ap_start), 32'd0);
        tick();
        check("post_rst_start", 32'(bus.ap_start), 32'd1);

        // Fresh run after reset: multi-lane writes
        bus.ap_ready = 1'b1;
        set_lane(5, 32'h1234_5678);
        set_lane(7, 32'hCAFE_F00D);
        tick();
        clear_inputs();
        set_lane(5, 32'h0F0F_0F0F);
        tick();
        clear_inputs();
        bus.ap_done = 1'b1;
        tick();
        bus.ap_done = 1'b0;
        check("run3_cnt", 32'(bus.run_cnt), 32'd1);
        capture(1'b0, got);
        exp_v = '0;
        exp_v[BUS_W-1-5*DATA_W -: DATA_W] = 32'h1D3B_5977;
        exp_v[BUS_W-1-7*DATA_W -: DATA_W] = 32'hCAFE_F00D;
        check_dump("run3", got, exp_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_run_ctrl.md
# kernel_run_ctrl

Run sequencer for an HLS kernel with an `ap_ctrl_hs` block-level handshake and NUM_LANES FIFO-style output streams (`D_out_k`). It launches the kernel NUM_RUNS times back to back. During each run it folds every output-stream write into a per-lane XOR checksum. After each run it shifts the checksums out on a 4-bit `data_out`/`data_valid` port, which lets the board wrapper check results without a simulator or a wide bus. It sits in the wrapper between the kernel top and the board I/O.

## Interface
- NUM_LANES, 8, number of kernel output streams
- DATA_W, 32, width of each stream word; multiple of 4
- NUM_RUNS, 2, kernel executions per reset; 1..63
- GAP_CYCLES, 16, idle cycles between the end of a dump and the next start; ≥1
- ap_clk  in  1  sole clock
- ap_rst  in  1  synchronous, active-high reset
- ap_done  in  1  kernel done pulse
- ap_ready  in  1  kernel accepted start
- ap_idle  in  1  kernel idle
- lane_write  in  NUM_LANES  per-lane write strobe (`D_out_k_write`)
- lane_din  in  NUM_LANES*DATA_W  per-lane data; lane k occupies bits [k*DATA_W +: DATA_W]
- ap_start  out  1  kernel start request
- probe_out  out  1  high while a run is in flight
- data_out  out  4  checksum nibble
- data_valid  out  1  data_out qualifier
- run_cnt  out  6  completed runs
- all_done  out  1  sticky; high after the final dump

## Operation
- States:
  - IDLE: go to START when ap_idle=1.
  - START: ap_start=1, probe_out=1. Go to WAIT when ap_ready=1. If ap_ready=1 and ap_done=1 arrive together, go directly to DUMP.
  - WAIT: probe_out=1. Go to DUMP when ap_done=1.
  - DUMP: NUM_LANES*DATA_W/4 cycles.
  - GAP: GAP_CYCLES cycles. Then go to START if run_cnt<NUM_RUNS, else FINISH.
  - FINISH: terminal until reset; all_done=1.
- Checksums:
  - All NUM_LANES checksums clear to 0 on entry to START.
  - In START and WAIT, each lane with lane_write=1 does chk[k] ^= lane_din[k].
  - The write in the same cycle as ap_done is included.
  - Writes in any other state are ignored.
- Dump order: lane 0 first, then lanes 1..NUM_LANES-1. Within a lane, most-significant nibble first. data_valid=1 on every DUMP cycle and 0 otherwise.
- run_cnt increments by 1 on the cycle ap_done is sampled in START or WAIT. It saturates at NUM_RUNS.
- ap_done seen in IDLE, DUMP, GAP or FINISH is ignored and does not count.
- ap_start is a level. It is held from START entry until ap_ready is sampled, and deasserts the cycle after.

## Timing
- Reset values: state=IDLE, ap_start=0, probe_out=0, data_out=0, data_valid=0, run_cnt=0, all_done=0, all checksums=0.
- All outputs are registered. No combinational path from any input to any output.
- ap_rst asserted in any state forces the reset values on the next edge, including mid-dump. A partially shifted checksum is discarded.
- IDLE→START: the first ap_start is high 1 cycle after ap_idle=1 is sampled. With ap_idle tied high, that is cycle 2 after ap_rst deasserts.
- ap_done sampled at edge N: the first data_valid nibble appears at edge N+1. The last appears at N+NUM_LANES*DATA_W/4, which is N+64 for the defaults.
- The next ap_start rises GAP_CYCLES+1 cycles after the last dump cycle.

## Structure
- Shared package `kernel_run_pkg` holds:
  - the state enum (IDLE, START, WAIT, DUMP, GAP, FINISH);
  - the nibble-count constant NIB_PER_LANE = DATA_W/4;
  - the dump-length constant DUMP_LEN = NUM_LANES*NIB_PER_LANE.
- Sub-module `lane_xor_acc`: one instance per lane. It holds the clear, enable and write-strobe accumulator and a parallel-load nibble shift register for the dump.
- Top level: FSM, counters, dump lane/nibble index.

## Test plan
- Single run: NUM_RUNS=1. Lane 3 writes 0x0000_00F0 then 0x0000_000F; the other lanes are silent; ap_done 100 cycles after ap_ready.
  - Lane 3 dumps nibbles 0,0,0,0,0,0,F,F at dump cycles 25..32.
  - All other nibbles are 0.
  - Then run_cnt=1 and all_done=1.
- Two runs, defaults:
  - Exactly two ap_start intervals, separated by 64+16+1 cycles from the first ap_done.
  - run_cnt=2, then FINISH.
  - A third ap_done pulse leaves run_cnt=2.
- Coincident events:
  - Same cycle: ap_ready=1, ap_done=1, lane_write[0]=1 with 0xDEADBEEF. The dump starts next cycle; lane 0 nibbles are D,E,A,D,B,E,E,F.
- Stray traffic:
  - lane_write pulses during GAP and DUMP do not alter the next run's checksum.
  - ap_done during GAP is not counted.
- Reset mid-dump:
  - ap_rst asserted at dump cycle 10 gives data_valid=0 and all outputs at reset values next cycle.
  - After release, the sequence restarts at run_cnt=0.
- Slow ready: ap_idle=0 for 20 cycles holds IDLE. ap_start then stays high for 7 cycles, until ap_ready, and deasserts the cycle after.
